// File: rtl/tx_queue.sv
`timescale 1ns/1ps
// tx_queue: DEPTH x 16-bit word FIFO feeding a byte serializer for a UART transmitter.
// Latency: a word pushed into an empty, idle queue is popped one edge later and launched
//          (tx_start) in the following cycle; the high byte goes first, then the low byte.
// Backpressure: full is registered; pushes while full are dropped unless the serializer
//               pops in the same cycle. The serializer waits on tx_rdy before each byte.
// Optional feature: define TXQ_OVERFLOW_EN to add a sticky ovfl flag with ovfl_clr.
module tx_queue #(
  parameter int DEPTH = 8  // power of two, 2..64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  output logic        full,
  output logic        busy,
  input  logic        tx_rdy,
  output logic        tx_start,
  output logic [7:0]  tx_data
`ifdef TXQ_OVERFLOW_EN
  ,
  output logic        ovfl,
  input  logic        ovfl_clr
`endif
);

  // Pointer and count widths; the count needs one extra bit to represent DEPTH itself.
  localparam int            AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   LP_DEPTH   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LP_CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] LP_PTR_ONE = AW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LD_HI = 3'd1,
    S_WT_HI = 3'd2,
    S_LD_LO = 3'd3,
    S_WT_LO = 3'd4
  } state_t;

  // Storage and control state.
  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_full;
  logic [15:0]   r_hold;
  state_t        r_state;

  logic          w_pop;
  logic          w_push;
  logic [AW:0]   w_count_nxt;

  // The serializer pops only from IDLE and only when a word is present; this means a
  // simultaneous push/pop can never happen on an empty FIFO.
  assign w_pop  = (r_state == S_IDLE) && (r_count != '0) && !rst;

  // A push into a full FIFO is still accepted when the pop frees the head slot this cycle.
  assign w_push = wr_en && (!r_full || w_pop) && !rst;

  // Next occupancy: push-only grows, pop-only shrinks, both or neither hold steady.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + LP_CNT_ONE;
      2'b01:   w_count_nxt = r_count - LP_CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // Word storage; contents need no reset because pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= wr_data;
    end
  end

  // Pointer, count and registered full-flag maintenance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + LP_PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + LP_PTR_ONE;
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == LP_DEPTH);
    end
  end

  // Serializer FSM: pop a word into hold, then hand out high and low byte on tx_rdy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_hold  <= 16'h0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_hold  <= r_mem[r_rptr];
            r_state <= S_LD_HI;
          end
        end
        S_LD_HI: begin
          if (tx_rdy) begin
            r_state <= S_WT_HI;
          end
        end
        // tx_rdy is expected to drop right after the launch; waiting for it to
        // return high means the transmitter has finished with the high byte.
        S_WT_HI: begin
          if (tx_rdy) begin
            r_state <= S_LD_LO;
          end
        end
        S_LD_LO: begin
          if (tx_rdy) begin
            r_state <= S_WT_LO;
          end
        end
        S_WT_LO: begin
          if (tx_rdy) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Launch pulse: only the LD states fire, and each LD state always moves on to a WT state,
  // so two back-to-back pulses cannot occur.
  always_comb begin
    tx_start = 1'b0;
    if ((r_state == S_LD_HI) || (r_state == S_LD_LO)) begin
      tx_start = tx_rdy;
    end
  end

  // Byte mux: high byte until the high byte has been handed over, low byte afterwards.
  always_comb begin
    tx_data = r_hold[15:8];
    if ((r_state == S_LD_LO) || (r_state == S_WT_LO)) begin
      tx_data = r_hold[7:0];
    end
  end

  assign full = r_full;
  assign busy = (r_count != '0) || (r_state != S_IDLE);

`ifdef TXQ_OVERFLOW_EN
  logic r_ovfl;
  logic w_reject;

  // A rejected push is a request arriving while full with no same-cycle pop.
  assign w_reject = wr_en && r_full && !w_pop;

  // Sticky overflow flag; a new rejection beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovfl <= 1'b0;
    end else if (w_reject) begin
      r_ovfl <= 1'b1;
    end else if (ovfl_clr) begin
      r_ovfl <= 1'b0;
    end
  end

  assign ovfl = r_ovfl;
`endif

endmodule

// File: tb/tb_tx_queue.sv
`timescale 1ns/1ps
// Directed bench for tx_queue (DEPTH=8): reset, latency, fill/drop, full push+pop,
// wrap-around ordering, reset mid-transfer and a long handshake stall.
module tb_tx_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        full;
  logic        busy;
  logic        tx_rdy;
  logic        tx_start;
  logic [7:0]  tx_data;
`ifdef TXQ_OVERFLOW_EN
  logic        ovfl;
  logic        ovfl_clr;
`endif

  always #5 clk = ~clk;

  tx_queue #(.DEPTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .busy     (busy),
    .tx_rdy   (tx_rdy),
    .tx_start (tx_start),
    .tx_data  (tx_data)
`ifdef TXQ_OVERFLOW_EN
    ,
    .ovfl     (ovfl),
    .ovfl_clr (ovfl_clr)
`endif
  );

  // UART stand-in: in auto mode it goes not-ready for two cycles after each launch.
  logic       uart_auto = 1'b0;
  logic       man_rdy   = 1'b1;
  logic [1:0] ub_cnt    = 2'd0;
  assign tx_rdy = uart_auto ? (ub_cnt == 2'd0) : man_rdy;

  always @(posedge clk) begin
    if (tx_start === 1'b1) ub_cnt <= 2'd2;
    else if (ub_cnt != 2'd0) ub_cnt <= ub_cnt - 2'd1;
  end

  // Byte log of every launched byte, plus back-to-back pulse detection.
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         n_start    = 0;
  int         n_dbl      = 0;
  logic       prev_start = 1'b0;

  always @(negedge clk) begin
    if (tx_start === 1'b1) begin
      got_q.push_back(tx_data);
      n_start++;
      if (prev_start) n_dbl++;
    end
    prev_start = (tx_start === 1'b1);
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((busy !== 1'b0) && (n < budget)) begin
      step();
      n++;
    end
    chk(tag, busy, 1'b0);
  endtask

  task automatic chk_log(input string tag);
    int n;
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_b%0d", tag, i), got_q[i], exp_q[i]);
    end
  endtask

  initial begin
    int          bad_s;
    int          bad_d;
    int          snap;
    int          guard;
    logic [15:0] w;

    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = 16'h0000;
`ifdef TXQ_OVERFLOW_EN
    ovfl_clr = 1'b0;
`endif

    // Reset state.
    step();
    step();
    chk("rst_full", full, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_start", tx_start, 1'b0);
    chk("rst_data", tx_data, 8'h00);
`ifdef TXQ_OVERFLOW_EN
    chk("rst_ovfl", ovfl, 1'b0);
`endif
    rst = 1'b0;
    step();

    // Single word with latency: push at edge N, pop at N+1, launch before N+2.
    got_q.delete();
    uart_auto = 1'b1;
    push(16'hA55A);
    chk("sw_busy", busy, 1'b1);
    chk("sw_start_n", tx_start, 1'b0);
    step();
    chk("sw_start_n1", tx_start, 1'b1);
    chk("sw_data_hi", tx_data, 8'hA5);
    step();
    chk("sw_start_n2", tx_start, 1'b0);
    chk("sw_data_wt", tx_data, 8'hA5);
    wait_idle("sw_idle", 40);
    exp_q = '{8'hA5, 8'h5A};
    chk_log("sw_log");

    // Fill: nine words fit (one in hold, eight queued), the tenth is dropped.
    got_q.delete();
    uart_auto = 1'b0;
    man_rdy   = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      push(16'(i));
      if (i == 8) chk("fill_notfull7", full, 1'b0);
    end
    chk("fill_full", full, 1'b1);
    chk("fill_start", tx_start, 1'b0);
    chk("fill_data", tx_data, 8'h00);
    push(16'h000A);
    chk("fill_full_after_drop", full, 1'b1);
`ifdef TXQ_OVERFLOW_EN
    chk("fill_ovfl_set", ovfl, 1'b1);
    ovfl_clr = 1'b1;
    step();
    ovfl_clr = 1'b0;
    chk("fill_ovfl_clr", ovfl, 1'b0);
`endif
    uart_auto = 1'b1;
    wait_idle("fill_idle", 400);
    exp_q.delete();
    for (int i = 1; i <= 9; i++) begin
      exp_q.push_back(8'h00);
      exp_q.push_back(8'(i));
    end
    chk_log("fill_log");

    // Full FIFO with push in the IDLE pop cycle.
    got_q.delete();
    uart_auto = 1'b0;
    man_rdy   = 1'b0;
    push(16'h1111);
    for (int i = 1; i <= 8; i++) push(16'h2000 + 16'(i));
    chk("fpp_full", full, 1'b1);
    man_rdy = 1'b1;
    step();
    step();
    step();
    step();
    man_rdy = 1'b0;
    chk("fpp_full_idle", full, 1'b1);
    chk("fpp_start_idle", tx_start, 1'b0);
    push(16'hBEEF);
    chk("fpp_full_after", full, 1'b1);
`ifdef TXQ_OVERFLOW_EN
    chk("fpp_ovfl", ovfl, 1'b0);
`endif
    uart_auto = 1'b1;
    wait_idle("fpp_idle", 400);
    exp_q = '{8'h11, 8'h11};
    for (int i = 1; i <= 8; i++) begin
      exp_q.push_back(8'h20);
      exp_q.push_back(8'(i));
    end
    exp_q.push_back(8'hBE);
    exp_q.push_back(8'hEF);
    chk_log("fpp_log");

    // Wrap-around: 20 words through an 8-deep FIFO, pushed whenever not full.
    got_q.delete();
    uart_auto = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 20; i++) begin
      guard = 0;
      while ((full !== 1'b0) && (guard < 100)) begin
        step();
        guard++;
      end
      w = 16'h30C0 + 16'h0101 * 16'(i);
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
      push(w);
    end
    wait_idle("wrap_idle", 800);
    chk_log("wrap_log");

    // Reset while in WT_LO with three words queued.
    got_q.delete();
    uart_auto = 1'b0;
    man_rdy   = 1'b0;
    push(16'h4142);
    push(16'h5001);
    push(16'h5002);
    push(16'h5003);
    man_rdy = 1'b1;
    step();
    step();
    step();
    man_rdy = 1'b0;
    chk("rmid_wtlo_data", tx_data, 8'h42);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rmid_busy", busy, 1'b0);
    chk("rmid_full", full, 1'b0);
    chk("rmid_start", tx_start, 1'b0);
    chk("rmid_data", tx_data, 8'h00);
    snap    = n_start;
    man_rdy = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("rmid_no_start", n_start - snap, 0);
    chk("rmid_still_idle", busy, 1'b0);
    got_q.delete();
    uart_auto = 1'b1;
    push(16'h6162);
    wait_idle("rmid_idle", 40);
    exp_q = '{8'h61, 8'h62};
    chk_log("rmid_log");

    // Long handshake stall in LD_HI.
    got_q.delete();
    uart_auto = 1'b0;
    man_rdy   = 1'b0;
    push(16'h7A7B);
    step();
    bad_s = 0;
    bad_d = 0;
    for (int i = 0; i < 5000; i++) begin
      step();
      if (tx_start !== 1'b0) bad_s++;
      if (tx_data !== 8'h7A) bad_d++;
    end
    chk("stall_start", bad_s, 0);
    chk("stall_data", bad_d, 0);
    chk("stall_busy", busy, 1'b1);
    uart_auto = 1'b1;
    wait_idle("stall_idle", 40);
    exp_q = '{8'h7A, 8'h7B};
    chk_log("stall_log");

    chk("no_double_pulse", n_dbl, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/tx_queue.md
TX_QUEUE -- requirements
Module: tx_queue

Interface
REQ-001 Parameter DEPTH, default 8, number of 16-bit word entries in the queue; it SHALL be a power of two, 2..64.
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 wr_en  input  1  push request for wr_data.
REQ-005 wr_data  input  16  word to queue; [15:8] is sent first, [7:0] second.
REQ-006 full  output  1  queue holds DEPTH words.
REQ-007 busy  output  1  queue non-empty or serializer not in IDLE.
REQ-008 tx_rdy  input  1  UART transmitter ready; high only while the transmitter is idle.
REQ-009 tx_start  output  1  one-cycle launch pulse to the UART transmitter.
REQ-010 tx_data  output  8  byte presented to the UART transmitter; SHALL be valid in the cycle tx_start is high.

Function
REQ-011 The FIFO SHALL use a circular buffer of DEPTH x 16 with read and write pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus a count register of log2(DEPTH)+1 bits.
REQ-012 A push SHALL occur when wr_en=1 and (full=0 or a pop occurs in the same cycle); otherwise wr_en SHALL be ignored and the FIFO contents left unchanged.
REQ-013 A simultaneous push and pop SHALL leave the count unchanged, including when the FIFO is full and when it is empty.
REQ-014 full SHALL equal (count==DEPTH), is registered, and SHALL be valid the cycle after the push that fills the FIFO.
REQ-015 The serializer FSM SHALL have the states IDLE, LD_HI, WT_HI, LD_LO and WT_LO.
REQ-016 IDLE: if count!=0, the FSM SHALL pop the head word into a 16-bit hold register and go to LD_HI; else it SHALL remain in IDLE.
REQ-017 LD_HI: if tx_rdy=1, the FSM SHALL assert tx_start with tx_data=hold[15:8] and go to WT_HI; else it SHALL remain in LD_HI.
REQ-018 WT_HI: if tx_rdy=1, the FSM SHALL go to LD_LO; else it SHALL remain in WT_HI. tx_rdy low in the cycle after tx_start is the expected response.
REQ-019 LD_LO: behaves as LD_HI but with tx_data=hold[7:0] and next state WT_LO.
REQ-020 WT_LO: if tx_rdy=1, the FSM SHALL go to IDLE; else it SHALL remain in WT_LO.
REQ-021 tx_start SHALL be decoded combinationally from state and tx_rdy, and SHALL never be high on two consecutive cycles.
REQ-022 tx_data SHALL be hold[15:8] in IDLE, LD_HI and WT_HI, and hold[7:0] otherwise.
REQ-023 Latency: with an empty queue, FSM in IDLE and tx_rdy=1, a word pushed at edge N SHALL be popped at edge N+1, and tx_start SHALL be high during the cycle before edge N+2.
REQ-024 Bytes SHALL leave in push order with no reordering, duplication or loss of accepted words.

Reset
REQ-025 On rst=1 at a clock edge: pointers, count and hold SHALL be cleared to 0 and the state set to IDLE, so that full=0, busy=0, tx_start=0 and tx_data=8'h00.
REQ-026 Reset mid-transfer SHALL discard queued words and the word in progress; any byte the UART transmitter has already latched is not recalled.
REQ-027 rst SHALL take priority over wr_en and every FSM transition.

Configuration
REQ-028 With TXQ_OVERFLOW_EN defined, the module SHALL add the ports ovfl (output, 1 bit, sticky) and ovfl_clr (input, 1 bit).
REQ-029 With TXQ_OVERFLOW_EN defined, ovfl SHALL set on any rejected push and clear on ovfl_clr=1 or rst; if a set and a clear occur in the same cycle, the set SHALL win.
REQ-030 Without TXQ_OVERFLOW_EN, those ports SHALL be absent and rejected pushes SHALL be dropped silently.

Verification
REQ-031 Single word: push 16'hA55A with tx_rdy held 1 -> tx_start pulses with tx_data 8'hA5, then (after tx_rdy low/high) with 8'h5A; then busy=0.
REQ-032 Fill: DEPTH=8, tx_rdy=0, push 9 words 16'h0001..16'h0009 -> FSM pops 16'h0001 into hold and the FIFO keeps 16'h0002..0009 (8 entries), so full=1 and nothing is dropped; a 10th push is dropped (ovfl=1 when enabled); then release tx_rdy -> output sequence 00 01 00 02 ... 00 09.
REQ-033 Full with simultaneous push and pop: FIFO full, push 16'hBEEF in the IDLE pop cycle -> push accepted, count stays 8, 16'hBEEF sent last.
REQ-034 Wrap-around: 20 words pushed and drained with DEPTH=8 -> byte stream exactly matches push order across pointer wrap.
REQ-035 Reset mid-operation: assert rst in WT_LO with 3 words queued -> next cycle busy=0, full=0, tx_start=0, and no further tx_start until a new push.
REQ-036 Handshake stall: hold tx_rdy=0 for 5000 cycles in LD_HI -> tx_start stays 0 and tx_data stays stable at the high byte.
